// File: rtl/lm32_mul_tracker.sv
// -----------------------------------------------------------------------------
// lm32_mul_tracker
//
// Tracks the destination registers of multiplies as they move through the
// three-stage LM32 multiplier. The stages mirror the multiplier registers:
//   S1 - operand registers (advance when stall_x = 0)
//   S2 - product register  (advance when stall_m = 0)
//   S3 - result port       (advances every cycle)
// Each stage has a valid bit and a 5-bit destination tag. S2 also has a
// "fresh" flag. This ensures that an op held in S2 by a multi-cycle stall_m
// produces only one writeback pulse.
//
// Optional feature: define LM32_MUL_SCOREBOARD_EN to build the busy-register
// scoreboard (busy_o bitmap plus hazard_o check). Without the macro, both
// outputs are tied to 0 and no scoreboard logic is built.
//
// Ports
//   clk_i       in   1  clock, all state on the rising edge
//   rst_n_i     in   1  asynchronous active-low reset
//   stall_x     in   1  X-stage stall (gates S1)
//   stall_m     in   1  M-stage stall (gates S2)
//   issue_i     in   1  a multiply is presented in X
//   dest_i      in   5  destination register of the presented multiply
//   kill_x_i    in   1  discard the op presented in X
//   flush_i     in   1  discard every in-flight op
//   chk_a_i     in   5  source register A of the instruction in D
//   chk_b_i     in   5  source register B of the instruction in D
//   wb_valid_o  out  1  result port holds a fresh result
//   wb_dest_o   out  5  destination of that result
//   inflight_o  out  2  number of valid stages (0..3)
//   hazard_o    out  1  a source register matches an in-flight destination
//   busy_o      out 32  bitmap of in-flight destinations
// -----------------------------------------------------------------------------
module lm32_mul_tracker (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_x,
    input  logic        stall_m,
    input  logic        issue_i,
    input  logic [4:0]  dest_i,
    input  logic        kill_x_i,
    input  logic        flush_i,
    input  logic [4:0]  chk_a_i,
    input  logic [4:0]  chk_b_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_dest_o,
    output logic [1:0]  inflight_o,
    output logic        hazard_o,
    output logic [31:0] busy_o
);

    logic       s1_valid_reg;
    logic [4:0] s1_tag_reg;
    logic       s2_valid_reg;
    logic       s2_fresh_reg;
    logic [4:0] s2_tag_reg;
    logic       s3_valid_reg;
    logic [4:0] s3_tag_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_reg <= 1'b0;
            s1_tag_reg   <= 5'd0;
            s2_valid_reg <= 1'b0;
            s2_fresh_reg <= 1'b0;
            s2_tag_reg   <= 5'd0;
            s3_valid_reg <= 1'b0;
            s3_tag_reg   <= 5'd0;
        end else begin
            // S1: operand registers. A flush wins over the stall hold.
            if (flush_i) begin
                s1_valid_reg <= 1'b0;
            end else if (!stall_x) begin
                s1_valid_reg <= issue_i & ~kill_x_i;
            end
            if (!stall_x) begin
                s1_tag_reg <= dest_i;
            end

            // S2: product register. The fresh flag marks the first cycle after
            // a load. This lets S3 capture the op exactly once, even when
            // stall_m holds S2 for several cycles.
            if (flush_i) begin
                s2_valid_reg <= 1'b0;
                s2_fresh_reg <= 1'b0;
            end else if (!stall_m) begin
                s2_valid_reg <= s1_valid_reg;
                s2_fresh_reg <= 1'b1;
            end else begin
                s2_fresh_reg <= 1'b0;
            end
            if (!stall_m) begin
                s2_tag_reg <= s1_tag_reg;
            end

            // S3: result port. It is never stalled.
            s3_valid_reg <= s2_valid_reg & s2_fresh_reg & ~flush_i;
            s3_tag_reg   <= s2_tag_reg;
        end
    end

    assign wb_valid_o = s3_valid_reg;
    assign wb_dest_o  = s3_tag_reg;
    assign inflight_o = {1'b0, s1_valid_reg} + {1'b0, s2_valid_reg} + {1'b0, s3_valid_reg};

`ifdef LM32_MUL_SCOREBOARD_EN
    // Register 0 is hard-wired to zero, so it never counts as busy.
    assign busy_o[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_o[gi] = (s1_valid_reg && (s1_tag_reg == 5'(gi)))
                              | (s2_valid_reg && (s2_tag_reg == 5'(gi)))
                              | (s3_valid_reg && (s3_tag_reg == 5'(gi)));
        end
    endgenerate

    assign hazard_o = busy_o[chk_a_i] | busy_o[chk_b_i];
`else
    // The source-register inputs have no function without the scoreboard.
    logic unused_chk;
    assign unused_chk = ^{chk_a_i, chk_b_i};
    assign busy_o     = 32'd0;
    assign hazard_o   = 1'b0;
`endif

endmodule
